// File: rtl/crc_engine.sv
// Bit-serial reflected CRC engine: consumes DAT_W bits per trig, LSB first, accumulating until clr/rst.
// Optional macro CRC_INV_OUT_EN drives result as the inverted register instead of the raw register.
module crc_engine #(
  parameter int          CRC_W   = 16,
  parameter logic [15:0] POLY    = 16'hA001,
  parameter logic [15:0] INIT    = 16'h0000,
  parameter int          DAT_W   = 8,
  parameter logic [15:0] RESIDUE = 16'hB001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             trig,
  input  logic [DAT_W-1:0] inDat,
  output logic             busy,
  output logic             done,
  output logic [CRC_W-1:0] result,
  output logic             resOk
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam int CNT_W = $clog2(DAT_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DAT_W - 1);

  logic [0:0]       state;
  logic [CRC_W-1:0] crcReg;
  logic [CRC_W-1:0] crcNext;
  logic [DAT_W-1:0] shReg;
  logic [CNT_W-1:0] bitCnt;
  logic             fb;

  always_comb begin
    fb      = crcReg[0] ^ shReg[0];
    crcNext = (crcReg >> 1) ^ (fb ? POLY[CRC_W-1:0] : '0);
  end

  // clr outranks trig and also aborts a word in flight without a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      crcReg <= INIT[CRC_W-1:0];
      shReg  <= '0;
      bitCnt <= '0;
      done   <= 1'b0;
    end else if (clr) begin
      state  <= IDLE;
      crcReg <= INIT[CRC_W-1:0];
      shReg  <= '0;
      bitCnt <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            shReg  <= inDat;
            bitCnt <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          crcReg <= crcNext;
          shReg  <= shReg >> 1;
          if (bitCnt == LAST) begin
            bitCnt <= '0;
            state  <= IDLE;
            done   <= 1'b1;
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state == SHIFT);
  assign resOk = (crcReg == RESIDUE[CRC_W-1:0]);

`ifdef CRC_INV_OUT_EN
  assign result = ~crcReg;
`else
  assign result = crcReg;
`endif

endmodule

// File: tb/tb_crc_engine.sv
// Directed bench for crc_engine: a CRC-16/ARC instance and a Maxim CRC8 instance sharing clk/rst/clr.
// Expected values are hand-computed constants; CRC_INV_OUT_EN selects the inverted expectations.
module tb_crc_engine;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        trig16;
  logic [7:0]  dat16;
  logic        busy16;
  logic        done16;
  logic [15:0] result16;
  logic        resOk16;
  logic        trig8;
  logic [7:0]  dat8;
  logic        busy8;
  logic        done8;
  logic [7:0]  result8;
  logic        resOk8;

  int total;
  int bad;

`ifdef CRC_INV_OUT_EN
  localparam logic [15:0] OUTX16 = 16'hFFFF;
  localparam logic [7:0]  OUTX8  = 8'hFF;
`else
  localparam logic [15:0] OUTX16 = 16'h0000;
  localparam logic [7:0]  OUTX8  = 8'h00;
`endif

  crc_engine dut16 (
    .clk(clk), .rst(rst), .clr(clr), .trig(trig16), .inDat(dat16),
    .busy(busy16), .done(done16), .result(result16), .resOk(resOk16)
  );

  crc_engine #(
    .CRC_W(8), .POLY(16'h008C), .INIT(16'h0000), .DAT_W(8), .RESIDUE(16'h0000)
  ) dut8 (
    .clk(clk), .rst(rst), .clr(clr), .trig(trig8), .inDat(dat8),
    .busy(busy8), .done(done8), .result(result8), .resOk(resOk8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Feeds one byte starting just after a rising edge; trig is sampled at edge 1 and
  // inDat is scrambled afterwards to prove it was latched. Runs 9 edges.
  task automatic runWord(input bit is8, input logic [7:0] b,
                         output int doneAt, output int doneCnt, output logic [9:1] busyMask);
    if (is8) begin trig8 = 1'b1; dat8 = b; end
    else     begin trig16 = 1'b1; dat16 = b; end
    doneAt = -1;
    doneCnt = 0;
    busyMask = '0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        trig8 = 1'b0; trig16 = 1'b0;
        dat8 = ~b; dat16 = ~b;
      end
      busyMask[i] = is8 ? busy8 : busy16;
      if (is8 ? done8 : done16) begin
        doneCnt++;
        doneAt = i;
      end
    end
  endtask

  task automatic pulseClr;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_reset;
    total++; if (busy16 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy16 got=%b want=0", busy16); end
    total++; if (done16 !== 1'b0) begin bad++; $display("[TB] FAIL reset_done16 got=%b want=0", done16); end
    total++; if (result16 !== (16'h0000 ^ OUTX16)) begin bad++; $display("[TB] FAIL reset_result16 got=%h want=%h", result16, 16'h0000 ^ OUTX16); end
    total++; if (resOk16 !== 1'b0) begin bad++; $display("[TB] FAIL reset_resOk16 got=%b want=0", resOk16); end
    total++; if (result8 !== (8'h00 ^ OUTX8)) begin bad++; $display("[TB] FAIL reset_result8 got=%h want=%h", result8, 8'h00 ^ OUTX8); end
    total++; if (resOk8 !== 1'b1) begin bad++; $display("[TB] FAIL reset_resOk8 got=%b want=1", resOk8); end
  endtask

  // Nine chained words also exercise back-to-back trig during the done cycle.
  task automatic test_crc16_check;
    logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    int doneAt, doneCnt;
    logic [9:1] bm;
    pulseClr();
    for (int k = 0; k < 9; k++) begin
      runWord(1'b0, msg[k], doneAt, doneCnt, bm);
      total++; if (doneCnt !== 1 || doneAt !== 9) begin bad++; $display("[TB] FAIL crc16_done byte%0d got cnt=%0d at=%0d want cnt=1 at=9", k, doneCnt, doneAt); end
      total++; if (bm !== 9'b0_1111_1111) begin bad++; $display("[TB] FAIL crc16_busy byte%0d got=%b want=011111111", k, bm); end
    end
    total++; if (result16 !== (16'hBB3D ^ OUTX16)) begin bad++; $display("[TB] FAIL crc16_result got=%h want=%h", result16, 16'hBB3D ^ OUTX16); end
    total++; if (resOk16 !== 1'b0) begin bad++; $display("[TB] FAIL crc16_resOk_early got=%b want=0", resOk16); end
  endtask

  task automatic test_residue16;
    int doneAt, doneCnt;
    logic [9:1] bm;
    runWord(1'b0, 8'hC2, doneAt, doneCnt, bm);
    runWord(1'b0, 8'h44, doneAt, doneCnt, bm);
    total++; if (result16 !== (16'hB001 ^ OUTX16)) begin bad++; $display("[TB] FAIL residue16_result got=%h want=%h", result16, 16'hB001 ^ OUTX16); end
    total++; if (resOk16 !== 1'b1) begin bad++; $display("[TB] FAIL residue16_resOk got=%b want=1", resOk16); end
  endtask

  task automatic test_crc8;
    logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    int doneAt, doneCnt;
    logic [9:1] bm;
    pulseClr();
    for (int k = 0; k < 9; k++) runWord(1'b1, msg[k], doneAt, doneCnt, bm);
    total++; if (doneCnt !== 1 || doneAt !== 9) begin bad++; $display("[TB] FAIL crc8_done got cnt=%0d at=%0d want cnt=1 at=9", doneCnt, doneAt); end
    total++; if (result8 !== (8'hA1 ^ OUTX8)) begin bad++; $display("[TB] FAIL crc8_result got=%h want=%h", result8, 8'hA1 ^ OUTX8); end
    total++; if (resOk8 !== 1'b0) begin bad++; $display("[TB] FAIL crc8_resOk_early got=%b want=0", resOk8); end
    runWord(1'b1, 8'hA1, doneAt, doneCnt, bm);
    total++; if (result8 !== (8'h00 ^ OUTX8)) begin bad++; $display("[TB] FAIL crc8_zero got=%h want=%h", result8, 8'h00 ^ OUTX8); end
    total++; if (resOk8 !== 1'b1) begin bad++; $display("[TB] FAIL crc8_resOk got=%b want=1", resOk8); end
  endtask

  task automatic test_ignore_trig;
    int doneCnt, doneAt;
    pulseClr();
    doneCnt = 0;
    doneAt = -1;
    trig16 = 1'b1; dat16 = 8'h31;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      trig16 = (i == 4);
      dat16 = (i == 4) ? 8'hFF : 8'h00;
      if (done16) begin doneCnt++; doneAt = i; end
    end
    trig16 = 1'b0;
    total++; if (doneCnt !== 1 || doneAt !== 9) begin bad++; $display("[TB] FAIL ignore_done got cnt=%0d at=%0d want cnt=1 at=9", doneCnt, doneAt); end
    total++; if (result16 !== (16'hD4C1 ^ OUTX16)) begin bad++; $display("[TB] FAIL ignore_result got=%h want=%h", result16, 16'hD4C1 ^ OUTX16); end
    total++; if (busy16 !== 1'b0) begin bad++; $display("[TB] FAIL ignore_busy got=%b want=0", busy16); end
  endtask

  task automatic test_clr_abort;
    int doneCnt;
    pulseClr();
    trig16 = 1'b1; dat16 = 8'h31;
    @(posedge clk); #1;
    trig16 = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    total++; if (busy16 !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy got=%b want=0", busy16); end
    total++; if (result16 !== (16'h0000 ^ OUTX16)) begin bad++; $display("[TB] FAIL abort_result got=%h want=%h", result16, 16'h0000 ^ OUTX16); end
    doneCnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done16) doneCnt++;
      @(posedge clk); #1;
    end
    total++; if (doneCnt !== 0) begin bad++; $display("[TB] FAIL abort_done got=%0d want=0", doneCnt); end
    clr = 1'b1; trig16 = 1'b1; dat16 = 8'h55;
    @(posedge clk); #1;
    clr = 1'b0; trig16 = 1'b0;
    total++; if (busy16 !== 1'b0) begin bad++; $display("[TB] FAIL clrtrig_busy got=%b want=0", busy16); end
    @(posedge clk); #1;
    total++; if (busy16 !== 1'b0 || done16 !== 1'b0) begin bad++; $display("[TB] FAIL clrtrig_idle got busy=%b done=%b want 0 0", busy16, done16); end
  endtask

  task automatic test_async_reset;
    int doneAt, doneCnt, sawDone;
    logic [9:1] bm;
    pulseClr();
    trig16 = 1'b1; dat16 = 8'h31;
    @(posedge clk); #1;
    trig16 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #4;
    rst = 1'b1;
    #1;
    total++; if (busy16 !== 1'b0) begin bad++; $display("[TB] FAIL arst_busy got=%b want=0", busy16); end
    total++; if (result16 !== (16'h0000 ^ OUTX16)) begin bad++; $display("[TB] FAIL arst_result got=%h want=%h", result16, 16'h0000 ^ OUTX16); end
    #32;
    rst = 1'b0;
    sawDone = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done16 || busy16) sawDone++;
    end
    total++; if (sawDone !== 0) begin bad++; $display("[TB] FAIL arst_quiet got=%0d want=0", sawDone); end
    runWord(1'b0, 8'h0F, doneAt, doneCnt, bm);
    total++; if (doneCnt !== 1 || doneAt !== 9) begin bad++; $display("[TB] FAIL arst_done got cnt=%0d at=%0d want cnt=1 at=9", doneCnt, doneAt); end
    total++; if (result16 !== (16'h0440 ^ OUTX16)) begin bad++; $display("[TB] FAIL arst_result0F got=%h want=%h", result16, 16'h0440 ^ OUTX16); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    clr = 1'b0;
    trig16 = 1'b0; dat16 = '0;
    trig8 = 1'b0;  dat8 = '0;
    #22;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_crc16_check();
    test_residue16();
    test_crc8();
    test_ignore_trig();
    test_clr_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc_engine.md
CRC_ENGINE -- requirements
Module: crc_engine

Interface
REQ-001 SHALL have parameter CRC_W, default 16: CRC register width, legal 8..16.
REQ-002 SHALL have parameter POLY, default 16'hA001: reflected polynomial, low CRC_W bits used (8'h8C for the Maxim CRC8).
REQ-003 SHALL have parameter INIT, default 16'h0000: seed loaded at reset and on clr.
REQ-004 SHALL have parameter DAT_W, default 8: bits per trig, legal 1..16.
REQ-005 SHALL have parameter RESIDUE, default 16'hB001: value compared for resOk.
REQ-006 SHALL have port clk  in  1  single clock; all logic runs on its rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port clr  in  1  synchronous re-seed of the CRC register to INIT.
REQ-009 SHALL have port trig  in  1  start processing inDat; sampled only when idle.
REQ-010 SHALL have port inDat  in  DAT_W  data word, consumed LSB first.
REQ-011 SHALL have port busy  out  1  shifting in progress.
REQ-012 SHALL have port done  out  1  one-cycle pulse when a word completes.
REQ-013 SHALL have port result  out  CRC_W  current CRC, or its inverse per the configuration.
REQ-014 SHALL have port resOk  out  1  raw CRC register equals RESIDUE[CRC_W-1:0].

Function
REQ-015 SHALL implement states IDLE and SHIFT; IDLE->SHIFT on trig, SHIFT->IDLE after DAT_W bits.
REQ-016 SHALL latch inDat into an internal shift register on the edge where trig is sampled high in IDLE; later changes to inDat are ignored.
REQ-017 SHALL process one bit per clock: fb = crc[0]^bit; crc = (crc>>1) ^ (fb ? POLY : 0).
REQ-018 SHALL assert busy from the edge after the trig sample until the DAT_W-th shift edge.
REQ-019 SHALL assert done for exactly one cycle after the DAT_W-th shift edge, with result already final; trig-to-done latency is DAT_W cycles.
REQ-020 SHALL ignore trig while busy; no queueing, no error flag.
REQ-021 SHALL accept trig in the same cycle done is high (back-to-back words every DAT_W+1 cycles).
REQ-022 SHALL give clr priority over trig when both are high: register = INIT, trig is dropped.
REQ-023 SHALL treat clr during SHIFT as abort: register = INIT, state = IDLE, busy low next cycle, no done pulse.
REQ-024 SHALL leave the CRC register unchanged between words, so the CRC accumulates across trigs until clr or rst.
REQ-025 SHALL derive resOk combinationally from the raw register, independent of the configuration macro.

Reset
REQ-026 SHALL on rst force: register = INIT[CRC_W-1:0], state IDLE, busy = 0, done = 0, and the internal shift register and counter cleared.
REQ-027 SHALL on rst asserted mid-SHIFT abort immediately with no done pulse; on release first trig is accepted on the next edge.

Configuration
REQ-028 SHALL, with macro CRC_INV_OUT_EN defined, drive result = ~register (the inverted CRC form transmitted on the 1-Wire link); without it, result = register.

Verification
REQ-029 SHALL show: CRC_W=16, INIT=0, bytes "123456789" (31..39 hex) -> result 16'hBB3D (16'h44C2 with CRC_INV_OUT_EN), done once per byte, 8 cycles after each trig.
REQ-030 SHALL show: CRC_W=8, POLY=8'h8C, "123456789" -> result 8'hA1; then byte A1 -> register 8'h00, resOk=1 with RESIDUE=0.
REQ-031 SHALL show: CRC16 of "123456789" followed by inverted CRC bytes C2, 44 -> raw register 16'hB001, resOk=1.
REQ-032 SHALL show: trig pulsed again 3 cycles into SHIFT -> ignored, single done, result unchanged versus a single trig.
REQ-033 SHALL show: clr at shift cycle 4 -> busy low next cycle, no done, register = INIT; clr+trig same cycle -> no busy.
REQ-034 SHALL show: rst asserted mid-SHIFT for 33 ns off-edge -> outputs reset asynchronously; CRC of byte 0F after release matches a fresh run.
